// File: rtl/fixed_accumulator.sv
// -----------------------------------------------------------------------------
// fixed_accumulator
//
// Sums LENGTH signed Q8.8 products from a fixed-point multiplier into a wide
// accumulator. The accumulator carries GUARD_BITS of headroom so it never
// wraps. The result is clamped once, at the end, to the signed DATA_WIDTH
// range. Multiplier overflow flags are ORed into a sticky V bit.
//
// Parameters
//   DATA_WIDTH  sample width (signed Q8.8, default 16)
//   LENGTH      products summed per result, 1..256 (default 4)
//   GUARD_BITS  extra accumulator headroom bits (default 8)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      begin a new accumulation (honoured in IDLE only)
//   in_valid   in_data / in_v valid
//   in_ready   block accepts a product this cycle (ACCUM)
//   in_data    signed Q8.8 product
//   in_v       multiplier overflow flag for in_data
//   out_valid  result available (DONE)
//   out_ready  consumer accepts the result
//   out_data   saturated signed Q8.8 sum
//   N, Z, V    negative / zero / overflow-or-saturation flags of the result
//   C          carry, always 0
//   busy       state is not IDLE
// -----------------------------------------------------------------------------
module fixed_accumulator #(
  parameter int DATA_WIDTH = 16,
  parameter int LENGTH     = 4,
  parameter int GUARD_BITS = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_v,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  N,
  output logic                  Z,
  output logic                  V,
  output logic                  C,
  output logic                  busy
);

  localparam int ACC_WIDTH = DATA_WIDTH + GUARD_BITS;
  localparam int CNT_WIDTH = $clog2(LENGTH + 1);
  // Count value held before the transfer that completes the result.
  localparam logic [CNT_WIDTH-1:0] LAST_COUNT = CNT_WIDTH'(LENGTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ACCUM = 2'b01,
    DONE  = 2'b10
  } state_t;

  state_t                       state_r;
  logic signed [ACC_WIDTH-1:0]  acc_r;
  logic [CNT_WIDTH-1:0]         count_r;
  logic                         sticky_v_r;
  logic                         in_ready_r;
  logic                         out_valid_r;
  logic                         busy_r;
  logic [DATA_WIDTH-1:0]        out_data_r;
  logic                         n_r;
  logic                         z_r;
  logic                         v_r;

  logic signed [ACC_WIDTH-1:0]  ext_s;
  logic signed [ACC_WIDTH-1:0]  sum_s;
  logic signed [ACC_WIDTH-1:0]  sat_max_s;
  logic signed [ACC_WIDTH-1:0]  sat_min_s;
  logic [DATA_WIDTH-1:0]        res_s;
  logic                         clamp_s;
  logic                         xfer_s;
  logic                         last_s;

  // Sign-extend the incoming product to accumulator width.
  assign ext_s     = {{GUARD_BITS{in_data[DATA_WIDTH-1]}}, in_data};
  assign sum_s     = acc_r + ext_s;
  // Signed DATA_WIDTH limits expressed at accumulator width.
  assign sat_max_s = {{(GUARD_BITS + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
  assign sat_min_s = {{(GUARD_BITS + 1){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};

  assign xfer_s    = (state_r == ACCUM) && in_valid && in_ready_r;
  assign last_s    = (count_r == LAST_COUNT);

  // Clamp the post-transfer sum into the signed output range.
  always_comb begin
    res_s   = sum_s[DATA_WIDTH-1:0];
    clamp_s = 1'b0;
    if (sum_s > sat_max_s) begin
      res_s   = {1'b0, {(DATA_WIDTH - 1){1'b1}}};
      clamp_s = 1'b1;
    end else if (sum_s < sat_min_s) begin
      res_s   = {1'b1, {(DATA_WIDTH - 1){1'b0}}};
      clamp_s = 1'b1;
    end else begin
      res_s   = sum_s[DATA_WIDTH-1:0];
      clamp_s = 1'b0;
    end
  end

  // Control FSM with accumulator datapath and registered result/handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      acc_r       <= {ACC_WIDTH{1'b0}};
      count_r     <= {CNT_WIDTH{1'b0}};
      sticky_v_r  <= 1'b0;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      out_data_r  <= {DATA_WIDTH{1'b0}};
      n_r         <= 1'b0;
      z_r         <= 1'b0;
      v_r         <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            state_r    <= ACCUM;
            acc_r      <= {ACC_WIDTH{1'b0}};
            count_r    <= {CNT_WIDTH{1'b0}};
            sticky_v_r <= 1'b0;
            in_ready_r <= 1'b1;
            busy_r     <= 1'b1;
          end else begin
            state_r    <= IDLE;
          end
        end
        ACCUM: begin
          if (xfer_s) begin
            acc_r      <= sum_s;
            count_r    <= count_r + {{(CNT_WIDTH - 1){1'b0}}, 1'b1};
            sticky_v_r <= sticky_v_r | in_v;
            if (last_s) begin
              // Result is captured on the same edge that enters DONE.
              state_r     <= DONE;
              in_ready_r  <= 1'b0;
              out_valid_r <= 1'b1;
              out_data_r  <= res_s;
              n_r         <= res_s[DATA_WIDTH-1];
              z_r         <= (res_s == {DATA_WIDTH{1'b0}});
              v_r         <= sticky_v_r | in_v | clamp_s;
            end else begin
              state_r     <= ACCUM;
            end
          end else begin
            state_r <= ACCUM;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_r     <= IDLE;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
          end else begin
            state_r     <= DONE;
          end
        end
        default: begin
          state_r     <= IDLE;
          in_ready_r  <= 1'b0;
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign out_data  = out_data_r;
  assign N         = n_r;
  assign Z         = z_r;
  assign V         = v_r;
  assign C         = 1'b0;

endmodule

// File: tb/tb_fixed_accumulator.sv
// -----------------------------------------------------------------------------
// tb_fixed_accumulator
//
// Directed and randomized transactions for fixed_accumulator (LENGTH=4).
// Expected results come from an integer reference: sum the signed products,
// clamp to the 16-bit signed range, and OR the overflow flags with the clamp.
// -----------------------------------------------------------------------------
module tb_fixed_accumulator;

  localparam int DW  = 16;
  localparam int LEN = 4;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          in_v;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          N;
  logic          Z;
  logic          V;
  logic          C;
  logic          busy;

  int checks;
  int errors;

  logic [DW-1:0] d_arr [LEN];
  logic          v_arr [LEN];

  fixed_accumulator #(
    .DATA_WIDTH (16),
    .LENGTH     (4),
    .GUARD_BITS (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_v      (in_v),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .N         (N),
    .Z         (Z),
    .V         (V),
    .C         (C),
    .busy      (busy)
  );

  // 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer sum, clamp, sticky overflow.
  task automatic model(output logic [DW-1:0] od, output logic n, output logic z,
                       output logic v);
    int s;
    s = 0;
    v = 1'b0;
    for (int i = 0; i < LEN; i++) begin
      s = s + int'($signed(d_arr[i]));
      v = v | v_arr[i];
    end
    if (s > 32767) begin
      od = 16'h7FFF;
      v  = 1'b1;
    end else if (s < -32768) begin
      od = 16'h8000;
      v  = 1'b1;
    end else begin
      od = 16'(s);
    end
    n = od[DW-1];
    z = (od == 16'h0000);
  endtask

  // One full transaction using d_arr/v_arr. gaps>0 inserts random idle cycles
  // (with garbage on in_data/in_v and a stray start) between transfers.
  task automatic run_txn(input string tag, input int max_gap, input int hold);
    logic [DW-1:0] e_od;
    logic          e_n;
    logic          e_z;
    logic          e_v;
    logic [DW-1:0] held;
    model(e_od, e_n, e_z, e_v);
    check({tag, ".idle_ready"}, 32'(in_ready), 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, ".accum_ready"}, 32'(in_ready), 32'd1);
    check({tag, ".accum_busy"}, 32'(busy), 32'd1);
    for (int i = 0; i < LEN; i++) begin
      int g;
      g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      for (int k = 0; k < g; k++) begin
        in_valid = 1'b0;
        in_data  = 16'($urandom);
        in_v     = 1'($urandom);
        start    = 1'b1;
        tick();
        start    = 1'b0;
      end
      in_valid = 1'b1;
      in_data  = d_arr[i];
      in_v     = v_arr[i];
      tick();
      in_valid = 1'b0;
      in_v     = 1'b0;
      check({tag, ".ovalid_step"}, 32'(out_valid), (i == LEN - 1) ? 32'd1 : 32'd0);
    end
    check({tag, ".in_ready_done"}, 32'(in_ready), 32'd0);
    check({tag, ".out_data"}, 32'(out_data), 32'(e_od));
    check({tag, ".N"}, 32'(N), 32'(e_n));
    check({tag, ".Z"}, 32'(Z), 32'(e_z));
    check({tag, ".V"}, 32'(V), 32'(e_v));
    check({tag, ".C"}, 32'(C), 32'd0);
    held = e_od;
    for (int k = 0; k < hold; k++) begin
      start = 1'b1;
      tick();
      start = 1'b0;
      check({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
      check({tag, ".hold_data"}, 32'(out_data), 32'(held));
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, ".ovalid_clear"}, 32'(out_valid), 32'd0);
    check({tag, ".busy_clear"}, 32'(busy), 32'd0);
  endtask

  task automatic fill(input logic [DW-1:0] a, input logic [DW-1:0] b,
                      input logic [DW-1:0] c_, input logic [DW-1:0] d);
    d_arr[0] = a;
    d_arr[1] = b;
    d_arr[2] = c_;
    d_arr[3] = d;
    for (int i = 0; i < LEN; i++) v_arr[i] = 1'b0;
  endtask

  // Linear sequence of directed steps followed by random transactions.
  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 16'h0000;
    in_v      = 1'b0;
    out_ready = 1'b0;
    #2;
    check("rst.in_ready", 32'(in_ready), 32'd0);
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.out_data", 32'(out_data), 32'd0);
    check("rst.flags", 32'({N, Z, V, C}), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Basic sum 4 x 13.125 = 52.5
    fill(16'h0D20, 16'h0D20, 16'h0D20, 16'h0D20);
    run_txn("basic", 0, 0);
    check("basic.const", 32'(out_data), 32'h3480);

    // Positive and negative saturation.
    fill(16'h7F60, 16'h7F60, 16'h7F60, 16'h7F60);
    run_txn("possat", 0, 0);
    fill(16'h8082, 16'h8082, 16'h8082, 16'h8082);
    run_txn("negsat", 0, 0);

    // Clamp boundaries: exactly max, one past max, exactly min.
    fill(16'h2000, 16'h2000, 16'h2000, 16'h1FFF);
    run_txn("edge_max", 0, 0);
    fill(16'h2000, 16'h2000, 16'h2000, 16'h2000);
    run_txn("edge_over", 0, 0);
    fill(16'hE000, 16'hE000, 16'hE000, 16'hE000);
    run_txn("edge_min", 0, 0);

    // Cancel to zero with idle cycles between transfers.
    fill(16'h0D20, 16'hF2E0, 16'h0640, 16'hF9C0);
    run_txn("cancel", 2, 0);

    // Sticky overflow on the second product only.
    fill(16'h0100, 16'h0100, 16'h0100, 16'h0100);
    v_arr[1] = 1'b1;
    run_txn("sticky", 0, 0);

    // Back-pressure: out_ready low for 3 cycles in DONE.
    fill(16'h0123, 16'hFF00, 16'h0456, 16'h0011);
    run_txn("hold", 0, 3);

    // Reset in the middle of an accumulation.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_data  = 16'h1000;
      tick();
    end
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst.in_ready", 32'(in_ready), 32'd0);
    check("mid_rst.busy", 32'(busy), 32'd0);
    check("mid_rst.out_valid", 32'(out_valid), 32'd0);
    tick();
    rst_n = 1'b1;
    // Inputs offered without start must be ignored.
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_data  = 16'h7000;
      tick();
      check("post_rst.no_ready", 32'(in_ready), 32'd0);
      check("post_rst.no_valid", 32'(out_valid), 32'd0);
    end
    in_valid = 1'b0;
    fill(16'h0080, 16'h0080, 16'h0080, 16'h0080);
    run_txn("post_rst", 0, 0);

    // Randomized transactions.
    for (int t = 0; t < 20; t++) begin
      for (int i = 0; i < LEN; i++) begin
        d_arr[i] = (t % 2 == 0) ? 16'($urandom) : 16'($urandom_range(16'h0800, 0) - 16'h0400);
        v_arr[i] = ($urandom_range(7, 0) == 0);
      end
      run_txn("rand", 2, int'($urandom_range(2, 0)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fixed_accumulator.md
FIXED_ACCUMULATOR -- requirements
Module: fixed_accumulator

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- DATA_WIDTH, 16, signed Q8.8 sample width.
- LENGTH, 4, products summed per result; legal range 1..256.
- GUARD_BITS, 8, extra accumulator headroom bits.

REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all state updates on the rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- start, in, 1, begin a new accumulation; sampled in IDLE only.
- in_valid, in, 1, in_data and in_v are valid.
- in_ready, out, 1, block accepts a product this cycle.
- in_data, in, DATA_WIDTH, signed Q8.8 product from the fixed-point multiplier.
- in_v, in, 1, multiplier overflow flag for in_data.
- out_valid, out, 1, result available.
- out_ready, in, 1, consumer accepts the result.
- out_data, out, DATA_WIDTH, saturated signed Q8.8 sum.
- N, out, 1, result negative.
- Z, out, 1, result zero.
- V, out, 1, overflow or saturation occurred.
- C, out, 1, carry; constant 0.
- busy, out, 1, state is not IDLE.

Function
REQ-003 FSM states SHALL be IDLE, ACCUM and DONE.
REQ-004 IDLE: in_ready=0 and out_valid=0; start=1 moves to ACCUM next cycle and clears the accumulator, count and sticky-V.
REQ-005 ACCUM: in_ready=1; a transfer occurs when in_valid and in_ready are both 1.
REQ-006 On each transfer: acc += sign-extended in_data (width DATA_WIDTH+GUARD_BITS); sticky_v |= in_v; count increments.
REQ-007 Cycles with in_valid=0 SHALL NOT change acc, count or sticky_v.
REQ-008 The transfer that makes count equal LENGTH moves the FSM to DONE; out_valid rises the next cycle, giving a latency of one cycle after the last accepted product.
REQ-009 On DONE entry, out_data, N, Z and V are registered:
- out_data = acc clamped to [0x8000, 0x7FFF].
- N = out_data MSB.
- Z = (out_data == 0).
- V = sticky_v OR (clamp applied).
REQ-010 DONE: out_valid=1 and in_ready=0; out_data and the flags hold stable until out_valid and out_ready are both 1, then the FSM returns to IDLE.
REQ-011 start SHALL be ignored in ACCUM and DONE.
REQ-012 out_data and flags keep their last value in IDLE and ACCUM; they are valid only while out_valid=1.
REQ-013 The accumulator SHALL NOT wrap for any LENGTH of 256 or less; only the final clamp limits the result.
REQ-014 C SHALL be 0 at all times.

Reset
REQ-015 rst_n=0 SHALL immediately, without waiting for clk:
- force the state to IDLE;
- drive acc, count, sticky_v, out_data, N, Z, V, out_valid, in_ready and busy to 0.
REQ-016 Reset during ACCUM or DONE discards the partial or pending result; no out_valid pulse follows reset release.
REQ-017 After rst_n deasserts, a start pulse is required before any input is accepted.

Verification (LENGTH=4)
REQ-018 Basic sum: start; four transfers of 0x0D20 (13.125) -> out_data=0x3480 (52.5), N=0, Z=0, V=0; out_valid one cycle after the fourth transfer.
REQ-019 Positive saturation: four transfers of 0x7F60 -> out_data=0x7FFF, N=0, V=1.
REQ-020 Negative saturation: four transfers of 0x8082 -> out_data=0x8000, N=1, V=1.
REQ-021 Cancel to zero: 0x0D20, 0xF2E0, 0x0640, 0xF9C0 with in_valid low between transfers -> out_data=0x0000, Z=1, V=0, and count unaffected by the idle cycles.
REQ-022 Sticky overflow: four transfers of 0x0100 with in_v=1 on the second only -> out_data=0x0400, V=1.
REQ-023 Handshake and reset:
- out_ready held 0 for 3 cycles in DONE -> out_data stable and out_valid=1 throughout.
- rst_n pulsed low after two transfers -> in_ready=0, busy=0 and out_valid=0 immediately; no result produced.
